yadmc_assoc_ctl: RTL and testbench

N-way set-associative write-back cache controller for the SDRAM path; generalises the direct-mapped controller to 1/2/4 ways.
- Adds a valid bit per line, round-robin victim selection, hardware tag init after reset, and a full-cache flush.
- Sits between the Wishbone slave port and the low-level SDRAM burst engine, which moves whole lines.
- Drives the external cache data RAM port address and write enables. Single clock domain; the command handshake to the burst engine is req/ack.

---
 rtl/yadmc_pkg.sv | 30 +++
 rtl/yadmc_tagram.sv | 21 ++
 rtl/yadmc_assoc_ctl.sv | 234 +++++++++++++++++++++++
 tb/tb_yadmc_assoc_ctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yadmc_pkg.sv
// Shared definitions for the set-associative SDRAM cache controller.
package yadmc_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK_HIT,
    ST_WAIT_ACK,
    ST_FLUSH_RD,
    ST_FLUSH_CHK,
    ST_FLUSH_WAIT
  } state_t;

  // Tag entry layout: {tag, valid, dirty}
  localparam int unsigned ENT_DIRTY = 0;
  localparam int unsigned ENT_VALID = 1;
  localparam int unsigned ENT_TAG   = 2;

  // Way-select width; a single-way cache still carries a 1-bit way field
  function automatic int unsigned calc_ways_depth(input int unsigned ways);
    return (ways <= 2) ? 1 : $clog2(ways);
  endfunction

  function automatic int unsigned calc_tagdepth(input int unsigned sdram_depth,
                                                input int unsigned cache_depth,
                                                input int unsigned cache_linedepth);
    return sdram_depth - cache_depth - cache_linedepth - 2;
  endfunction

endpackage

// File: rtl/yadmc_tagram.sv
// Single-port tag RAM with synchronous read; read data holds during writes.
module yadmc_tagram #(
  parameter int unsigned addr_w = 10,
  parameter int unsigned data_w = 13
) (
  input  logic              clk,
  input  logic [addr_w-1:0] addr,
  input  logic              we,
  input  logic [data_w-1:0] wdata,
  output logic [data_w-1:0] rdata
);

  logic [data_w-1:0] mem [2**addr_w];

  // Write or registered read, one access per cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/yadmc_assoc_ctl.sv
// N-way set-associative write-back cache controller between Wishbone and
// the SDRAM line burst engine.
module yadmc_assoc_ctl
  import yadmc_pkg::*;
#(
  parameter int unsigned sdram_depth     = 25,
  parameter int unsigned cache_depth     = 10,
  parameter int unsigned cache_linedepth = 2,
  parameter int unsigned cache_ways      = 2,
  localparam int unsigned ways_depth     = calc_ways_depth(cache_ways),
  localparam int unsigned cache_tagdepth = calc_tagdepth(sdram_depth, cache_depth, cache_linedepth)
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst,
  input  logic [31:0]                             wb_adr_i,
  input  logic                                    wb_we_i,
  input  logic [3:0]                              wb_sel_i,
  input  logic                                    wb_cyc_i,
  input  logic                                    wb_stb_i,
  output logic                                    wb_ack_o,
  output logic [ways_depth+cache_depth+cache_linedepth-1:0] data_adr_o,
  output logic [3:0]                              data_we_o,
  input  logic                                    flush_i,
  output logic                                    busy_o,
  output logic                                    cmd_evict_o,
  output logic                                    cmd_refill_o,
  output logic [ways_depth-1:0]                   cmd_way_o,
  output logic [sdram_depth-cache_linedepth-3:0]  evict_adr_o,
  output logic [sdram_depth-cache_linedepth-3:0]  refill_adr_o,
  input  logic                                    cmd_ack_i
);

  localparam int unsigned line_aw = cache_tagdepth + cache_depth;
  localparam int unsigned entry_w = cache_tagdepth + 2;
  localparam logic [ways_depth-1:0] last_way = ways_depth'(cache_ways - 1);

  state_t state, state_nx;

  logic [cache_depth-1:0]     sweep_idx;
  logic [ways_depth-1:0]      victim, flush_way, cmd_way, hit_way, data_way;
  logic                       flush_pending, evict_flag;
  logic [line_aw-1:0]         evict_adr, refill_adr;

  logic [cache_tagdepth-1:0]  wb_tag;
  logic [cache_depth-1:0]     wb_index;
  logic [cache_linedepth-1:0] wb_lindex;
  logic                       wb_req;

  logic [entry_w-1:0]         rd_entry [cache_ways];
  logic [cache_ways-1:0]      tag_we, hit;
  logic [cache_depth-1:0]     tag_addr;
  logic [entry_w-1:0]         tag_wdata;

  logic victim_dirty, flush_dirty, sweep_last, flush_way_last, sweep_step;
  logic unused_adr_bits;

  assign wb_tag    = wb_adr_i[sdram_depth-1 -: cache_tagdepth];
  assign wb_index  = wb_adr_i[cache_linedepth+2 +: cache_depth];
  assign wb_lindex = wb_adr_i[2 +: cache_linedepth];
  assign wb_req    = wb_cyc_i & wb_stb_i;
  assign unused_adr_bits = ^{wb_adr_i[31:sdram_depth], wb_adr_i[1:0]};

  for (genvar w = 0; w < cache_ways; w++) begin : g_way
    yadmc_tagram #(.addr_w(cache_depth), .data_w(entry_w)) u_tagram (
      .clk   (sys_clk),
      .addr  (tag_addr),
      .we    (tag_we[w]),
      .wdata (tag_wdata),
      .rdata (rd_entry[w])
    );
  end

  assign victim_dirty   = rd_entry[victim][ENT_VALID] & rd_entry[victim][ENT_DIRTY];
  assign flush_dirty    = rd_entry[flush_way][ENT_VALID] & rd_entry[flush_way][ENT_DIRTY];
  assign sweep_last     = &sweep_idx;
  assign flush_way_last = (flush_way == last_way);
  assign sweep_step     = ((state == ST_FLUSH_CHK) && !flush_dirty) ||
                          ((state == ST_FLUSH_WAIT) && cmd_ack_i);

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit     = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < cache_ways; w++) begin
      if (rd_entry[w][ENT_VALID] && (rd_entry[w][ENT_TAG +: cache_tagdepth] == wb_tag)) begin
        hit[w]  = 1'b1;
        hit_way = ways_depth'(w);
      end
    end
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_INIT;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:      if (sweep_last) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (flush_i || flush_pending) state_nx = ST_FLUSH_RD;
        else if (wb_req)              state_nx = ST_CHECK_HIT;
      end
      ST_CHECK_HIT: state_nx = (|hit) ? ST_IDLE : ST_WAIT_ACK;
      ST_WAIT_ACK:  if (cmd_ack_i) state_nx = ST_IDLE;
      ST_FLUSH_RD:  state_nx = ST_FLUSH_CHK;
      ST_FLUSH_CHK: begin
        if (flush_dirty)         state_nx = ST_FLUSH_WAIT;
        else if (flush_way_last) state_nx = sweep_last ? ST_IDLE : ST_FLUSH_RD;
      end
      ST_FLUSH_WAIT: begin
        if (cmd_ack_i) begin
          if (flush_way_last) state_nx = sweep_last ? ST_IDLE : ST_FLUSH_RD;
          else                state_nx = ST_FLUSH_CHK;
        end
      end
      default:      state_nx = ST_INIT;
    endcase
  end

  // Outputs, tag RAM port and burst commands per state
  always_comb begin
    wb_ack_o     = 1'b0;
    busy_o       = 1'b0;
    cmd_evict_o  = 1'b0;
    cmd_refill_o = 1'b0;
    tag_we       = '0;
    tag_addr     = wb_index;
    tag_wdata    = '0;
    data_way     = '0;
    case (state)
      ST_INIT: begin
        busy_o   = 1'b1;
        tag_addr = sweep_idx;
        tag_we   = '1;
      end
      ST_CHECK_HIT: begin
        data_way = hit_way;
        if (|hit) begin
          wb_ack_o = 1'b1;
          if (wb_we_i) begin
            tag_we    = hit;
            tag_wdata = {wb_tag, 1'b1, 1'b1};
          end
        end
      end
      ST_WAIT_ACK: begin
        tag_addr     = refill_adr[cache_depth-1:0];
        data_way     = cmd_way;
        cmd_refill_o = 1'b1;
        cmd_evict_o  = evict_flag;
        if (cmd_ack_i) begin
          wb_ack_o        = wb_req;
          tag_we[cmd_way] = 1'b1;
          tag_wdata       = {refill_adr[line_aw-1 -: cache_tagdepth], 1'b1, wb_req & wb_we_i};
        end
      end
      ST_FLUSH_RD: begin
        busy_o   = 1'b1;
        tag_addr = sweep_idx;
      end
      ST_FLUSH_CHK: begin
        busy_o   = 1'b1;
        tag_addr = sweep_idx;
        if (!flush_dirty) tag_we[flush_way] = 1'b1;
      end
      ST_FLUSH_WAIT: begin
        busy_o      = 1'b1;
        tag_addr    = sweep_idx;
        cmd_evict_o = 1'b1;
        if (cmd_ack_i) tag_we[flush_way] = 1'b1;
      end
      default: ;
    endcase
  end

  assign data_adr_o   = {data_way, wb_index, wb_lindex};
  assign data_we_o    = wb_sel_i & {4{wb_ack_o & wb_we_i}};
  assign cmd_way_o    = cmd_way;
  assign evict_adr_o  = evict_adr;
  assign refill_adr_o = refill_adr;

  // Sweep counters, victim pointer and latched command addresses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sweep_idx     <= '0;
      flush_way     <= '0;
      victim        <= '0;
      cmd_way       <= '0;
      evict_flag    <= 1'b0;
      evict_adr     <= '0;
      refill_adr    <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        ST_INIT: sweep_idx <= sweep_idx + 1'b1;
        ST_CHECK_HIT: begin
          if (!(|hit)) begin
            evict_flag <= victim_dirty;
            evict_adr  <= {rd_entry[victim][ENT_TAG +: cache_tagdepth], wb_index};
            refill_adr <= {wb_tag, wb_index};
            cmd_way    <= victim;
          end
        end
        ST_WAIT_ACK: begin
          if (cmd_ack_i) victim <= (victim == last_way) ? '0 : victim + 1'b1;
        end
        ST_FLUSH_CHK: begin
          if (flush_dirty) begin
            evict_adr <= {rd_entry[flush_way][ENT_TAG +: cache_tagdepth], sweep_idx};
            cmd_way   <= flush_way;
          end
        end
        default: ;
      endcase
      // Walk ways within a set, then advance to the next set
      if (sweep_step) begin
        if (flush_way_last) begin
          flush_way <= '0;
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_last) flush_pending <= 1'b0;
        end else begin
          flush_way <= flush_way + 1'b1;
        end
      end
      // A new request outranks completion so a late flush is never lost
      if (flush_i && (state != ST_IDLE)) flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_yadmc_assoc_ctl.sv
// Self-checking bench for yadmc_assoc_ctl (2 ways, 1024 sets, 4-word lines).
module tb_yadmc_assoc_ctl;

  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        cmd_ack_i = 1'b0;
  logic        wb_ack_o, busy_o, cmd_evict_o, cmd_refill_o;
  logic [12:0] data_adr_o;
  logic [3:0]  data_we_o;
  logic [0:0]  cmd_way_o;
  logic [20:0] evict_adr_o, refill_adr_o;

  yadmc_assoc_ctl #(
    .sdram_depth(25), .cache_depth(10), .cache_linedepth(2), .cache_ways(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .data_adr_o(data_adr_o), .data_we_o(data_we_o), .flush_i(flush_i), .busy_o(busy_o),
    .cmd_evict_o(cmd_evict_o), .cmd_refill_o(cmd_refill_o), .cmd_way_o(cmd_way_o),
    .evict_adr_o(evict_adr_o), .refill_adr_o(refill_adr_o), .cmd_ack_i(cmd_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain arrays of lines per way and set
  int unsigned m_tag   [WAYS][SETS];
  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  int unsigned m_victim;

  function automatic void model_flush();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_tag[w][s] = 0; m_valid[w][s] = 0; m_dirty[w][s] = 0;
      end
  endfunction

  function automatic void model_reset();
    model_flush();
    m_victim = 0;
  endfunction

  function automatic void model_access(input logic [31:0] adr, input bit we,
                                       output bit hit, output int unsigned way,
                                       output bit ev, output int unsigned ev_adr,
                                       output int unsigned rf_adr);
    int unsigned tag, idx;
    tag = (adr >> 14) & 32'h7ff;
    idx = (adr >> 4) & 32'h3ff;
    hit = 0; way = 0; ev = 0; ev_adr = 0; rf_adr = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tag) begin
        hit = 1; way = w;
      end
    if (hit) begin
      if (we) m_dirty[way][idx] = 1;
    end else begin
      way    = m_victim;
      ev     = m_valid[way][idx] && m_dirty[way][idx];
      ev_adr = m_tag[way][idx] * SETS + idx;
      rf_adr = tag * SETS + idx;
      m_tag[way][idx] = tag; m_valid[way][idx] = 1; m_dirty[way][idx] = we;
      m_victim = (m_victim + 1) % WAYS;
    end
  endfunction

  // One Wishbone access with fixed-cycle expectations, burst engine acked after dly cycles
  task automatic run_access(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                            input int unsigned dly, input bit e_hit, input int unsigned e_way,
                            input bit e_ev, input int unsigned e_ev_adr,
                            input int unsigned e_rf_adr);
    int unsigned e_dadr;
    e_dadr = (e_way << 12) | ((adr >> 2) & 32'hfff);
    @(negedge sys_clk);
    wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge sys_clk);
    check("hit_ack", wb_ack_o, e_hit);
    if (e_hit) begin
      check("hit_data_we", data_we_o, we ? sel : 4'h0);
      check("hit_data_adr", data_adr_o, e_dadr);
      check("hit_no_cmd", cmd_refill_o | cmd_evict_o, 0);
      @(posedge sys_clk); #1;
    end else begin
      @(negedge sys_clk);
      check("refill_cmd", cmd_refill_o, 1);
      check("evict_cmd", cmd_evict_o, e_ev);
      check("cmd_way", cmd_way_o, e_way);
      check("refill_adr", refill_adr_o, e_rf_adr);
      if (e_ev) check("evict_adr", evict_adr_o, e_ev_adr);
      check("miss_wait_no_ack", wb_ack_o, 0);
      repeat (dly) @(negedge sys_clk);
      check("refill_hold", cmd_refill_o, 1);
      cmd_ack_i = 1'b1;
      #1;
      check("fill_ack", wb_ack_o, 1);
      check("fill_data_we", data_we_o, we ? sel : 4'h0);
      check("fill_data_adr", data_adr_o, e_dadr);
      @(posedge sys_clk); #1;
      cmd_ack_i = 1'b0;
      check("cmd_drop", cmd_refill_o | cmd_evict_o, 0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic model_run(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input int unsigned dly);
    bit h, e; int unsigned wy, ea, ra;
    model_access(adr, we, h, wy, e, ea, ra);
    run_access(adr, we, sel, dly, h, wy, e, ea, ra);
  endtask

  // Count cycles of busy after reset release (bounded)
  task automatic wait_init();
    int cnt; bit ack_seen;
    cnt = 0; ack_seen = 0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge sys_clk);
      cnt++;
      #1;
      ack_seen |= wb_ack_o;
      if (!busy_o) break;
    end
    check("init_busy_cycles", cnt, 1024);
    check("init_no_ack", ack_seen, 0);
  endtask

  typedef struct {
    logic [31:0] adr; bit we; logic [3:0] sel; int unsigned dly;
    bit hit; int unsigned way; bit ev; int unsigned ev_adr; int unsigned rf_adr;
  } vec_t;

  vec_t tbl [11];
  int unsigned exp_q [$];
  int unsigned got_q [$];
  logic [31:0] last_adr;

  initial begin
    //           adr          we sel   dly hit way ev ev_adr  rf_adr
    tbl[0]  = '{32'h00000040, 0, 4'hf, 5, 0, 0, 0, 0,      32'h004};
    tbl[1]  = '{32'h00000040, 0, 4'hf, 0, 1, 0, 0, 0,      0};
    tbl[2]  = '{32'h00000040, 1, 4'h3, 0, 1, 0, 0, 0,      0};
    tbl[3]  = '{32'h00010040, 0, 4'hf, 2, 0, 1, 0, 0,      32'h1004};
    tbl[4]  = '{32'h00020040, 0, 4'hf, 1, 0, 0, 1, 32'h004, 32'h2004};
    tbl[5]  = '{32'h00000000, 0, 4'hf, 0, 0, 1, 0, 0,      32'h000};
    tbl[6]  = '{32'h00010000, 0, 4'hf, 3, 0, 0, 0, 0,      32'h1000};
    tbl[7]  = '{32'h00000000, 0, 4'hf, 0, 1, 1, 0, 0,      0};
    tbl[8]  = '{32'h00010004, 0, 4'hf, 0, 1, 0, 0, 0,      0};
    tbl[9]  = '{32'h00000008, 0, 4'hf, 0, 1, 1, 0, 0,      0};
    tbl[10] = '{32'h0001000c, 0, 4'hf, 0, 1, 0, 0, 0,      0};

    model_reset();
    repeat (2) @(negedge sys_clk);
    check("rst_busy", busy_o, 1);
    check("rst_ack", wb_ack_o, 0);
    check("rst_cmds", {cmd_evict_o, cmd_refill_o}, 0);
    check("rst_data_we", data_we_o, 0);
    sys_rst = 1'b0;
    wait_init();

    // Directed vectors: cold fill, hit, write hit, round-robin, dirty eviction, aliasing
    for (int i = 0; i < 11; i++) begin
      bit h, e; int unsigned wy, ea, ra;
      run_access(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dly, tbl[i].hit, tbl[i].way,
                 tbl[i].ev, tbl[i].ev_adr, tbl[i].rf_adr);
      model_access(tbl[i].adr, tbl[i].we, h, wy, e, ea, ra);
    end

    // Dirty lines at sets 3 and 7, then flush
    model_run(32'h00000030, 1, 4'hf, 1);
    model_run(32'h00000070, 1, 4'hf, 0);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[w][s] && m_dirty[w][s]) exp_q.push_back(m_tag[w][s] * SETS + s);
    model_flush();
    begin
      bit done; int bad_refill;
      done = 0; bad_refill = 0;
      @(negedge sys_clk); flush_i = 1'b1;
      @(negedge sys_clk); flush_i = 1'b0;
      check("flush_busy", busy_o, 1);
      for (int k = 0; k < 5000; k++) begin
        @(negedge sys_clk);
        if (cmd_ack_i) cmd_ack_i = 1'b0;
        if (!busy_o) begin done = 1; break; end
        if (cmd_refill_o) bad_refill++;
        if (cmd_evict_o) begin
          got_q.push_back(evict_adr_o);
          cmd_ack_i = 1'b1;
        end
      end
      cmd_ack_i = 1'b0;
      check("flush_done", done, 1);
      check("flush_no_refill", bad_refill, 0);
      check("flush_evict_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check("flush_evict_adr", got_q[i], exp_q[i]);
    end
    model_run(32'h00000030, 0, 4'hf, 0);

    // Randomized traffic over a small set/tag range to force conflicts
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
      model_run(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom_range(0, 3));
      last_adr = a;
    end

    // Reset while waiting for the burst engine
    @(negedge sys_clk);
    wb_adr_i = 32'h00000090; wb_we_i = 1'b0; wb_sel_i = 4'hf; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rst_pre_refill", cmd_refill_o, 1);
    #2 sys_rst = 1'b1;
    #1;
    check("rst_refill_drop", cmd_refill_o, 0);
    check("rst_busy_async", busy_o, 1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_init();
    model_reset();
    model_run(last_adr, 0, 4'hf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
